// File: rtl/prv32_mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that borrows the core's shared ALU.
// Shift-add multiply and restoring divide, one ALU add/sub per iteration.
module prv32_mdu_seq #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_alufn,
    input  logic [31:0] alu_r,
    input  logic        alu_cf
);

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;

    logic        is_div, is_rem, sign_a, sign_b, div_zero, div_ovf, neg_prep, div_ok, iter;
    logic [31:0] mag_a, mag_b, rem_shift, div_word, div_fix, special_word;
    logic [32:0] mul_sum;
    logic [63:0] prod, prod_fix;

    // Operand decode, only meaningful while in PREP (a_q/b_q still hold raw rs1/rs2).
    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    assign sign_a   = a_q[31] & (op_q == 3'b001 || op_q == 3'b010 ||
                                 op_q == 3'b100 || op_q == 3'b110);
    assign sign_b   = b_q[31] & (op_q == 3'b001 || op_q == 3'b100 || op_q == 3'b110);
    assign mag_a    = sign_a ? (~a_q + 32'd1) : a_q;
    assign mag_b    = sign_b ? (~b_q + 32'd1) : b_q;
    assign div_zero = is_div & (b_q == 32'd0);
    assign div_ovf  = is_div & ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
    // Divide-by-zero quotient must stay all-ones regardless of dividend sign.
    assign neg_prep = is_rem ? sign_a : ((sign_a ^ sign_b) & ~div_zero);
    assign special_word = div_zero ? (op_q[1] ? a_q : 32'hFFFF_FFFF)
                                   : (op_q[1] ? 32'd0 : 32'h8000_0000);

    // Iteration datapath: hi/lo double as rem/quotient for divides.
    assign iter      = (state_q == StIter);
    assign rem_shift = {hi_q[30:0], lo_q[31]};
    assign div_ok    = alu_cf | hi_q[31];
    assign mul_sum   = lo_q[0] ? {alu_cf, alu_r} : {1'b0, hi_q};

    assign alu_own   = iter;
    assign alu_a     = iter ? (op_q[2] ? rem_shift : hi_q) : 32'd0;
    assign alu_b     = iter ? b_q : 32'd0;
    assign alu_alufn = iter ? {3'b000, op_q[2]} : 4'b0000;

    assign prod     = {hi_q, lo_q};
    assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
    assign div_word = op_q[1] ? hi_q : lo_q;
    assign div_fix  = neg_q ? (~div_word + 32'd1) : div_word;

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_d    = funct3;
                        a_d     = rs1;
                        b_d     = rs2;
                        state_d = StPrep;
                    end
                end
                StPrep: begin
                    neg_d = neg_prep;
                    cnt_d = 5'd31;
                    hi_d  = 32'd0;
                    lo_d  = mag_a;
                    b_d   = mag_b;
                    if (FAST_SPECIAL && (div_zero || div_ovf)) begin
                        result_d = special_word;
                        state_d  = StDone;
                    end else begin
                        state_d = StIter;
                    end
                end
                StIter: begin
                    if (op_q[2]) begin
                        hi_d = div_ok ? alu_r : rem_shift;
                        lo_d = {lo_q[30:0], div_ok};
                    end else begin
                        hi_d = mul_sum[32:1];
                        lo_d = {mul_sum[0], lo_q[31:1]};
                    end
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    if (op_q[2]) begin
                        result_d = div_fix;
                    end else if (op_q[1:0] == 2'b00) begin
                        result_d = prod_fix[31:0];
                    end else begin
                        result_d = prod_fix[63:32];
                    end
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_prv32_mdu_seq.sv
// Self-checking bench for prv32_mdu_seq: directed RV32M ops plus random ops against an
// arithmetic reference, with a scoreboard keyed on the done pulse.
module tb_prv32_mdu_seq;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        busy, done, alu_own, alu_cf;
    logic [31:0] result, alu_a, alu_b, alu_r;
    logic [3:0]  alu_alufn;

    prv32_mdu_seq #(.FAST_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_alufn(alu_alufn),
        .alu_r(alu_r), .alu_cf(alu_cf)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in: add, or subtract with carry = no borrow.
    always_comb begin
        if (alu_alufn == 4'b0001) {alu_cf, alu_r} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                      {alu_cf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int own_cnt = 0;
    int alu_bad = 0;
    logic [2:0]  cur_op = 3'd0;
    logic [31:0] exp_q[$];
    int          start_q[$];
    int          lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (f)
            3'b000: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            3'b001: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                          r = sp[63:32]; end
            3'b010: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
                          r = sp[63:32]; end
            3'b011: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'b100: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = sa / sb;
            end
            3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = sa % sb;
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Monitor: ALU-bus hygiene every cycle, scoreboard pop on each done pulse.
    always @(negedge clk) begin
        logic [31:0] e;
        int s, l;
        if (alu_own === 1'b1) begin
            own_cnt++;
            if (alu_alufn !== (cur_op[2] ? 4'b0001 : 4'b0000)) alu_bad++;
        end else if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_alufn !== 4'd0) begin
            alu_bad++;
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                s = start_q.pop_front();
                l = lat_q.pop_front();
                check("result", result, e);
                check("latency", 32'(cyc - s), 32'(l));
            end
        end
    end

    task automatic push_exp(input logic [31:0] e, input int lat);
        exp_q.push_back(e);
        start_q.push_back(cyc);
        lat_q.push_back(lat);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input bit expect_done);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; cur_op = f; own_cnt = 0;
        if (expect_done) push_exp(e, lat);
        @(negedge clk);
        check("busy_in_accept_cycle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete(); start_q.delete(); lat_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_alu_own"}, {31'd0, alu_own}, 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alufn"}, {28'd0, alu_alufn}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        bit          spec;

        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        alu_bad = 0;

        issue(3'b000, 32'd7, 32'd6, 32'd42, 35, 1'b1);
        drain("mul_timeout");
        check("mul_alu_own_cycles", 32'(own_cnt), 32'd32);

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b1); drain("mulh_to");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b1); drain("mulhu_to");
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 35, 1'b1); drain("mulhsu_to");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b1); drain("div_to");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b1); drain("rem_to");
        issue(3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b1); drain("divu_to");
        issue(3'b111, 32'd100, 32'd7, 32'd2, 35, 1'b1); drain("remu_to");

        issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b1); drain("divu0_to");
        issue(3'b110, 32'd5, 32'd0, 32'd5, 2, 1'b1); drain("rem0_to");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b1); drain("divov_to");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b1); drain("remov_to");

        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = 32'd0;
            if (i % 4 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            spec = f[2] && (b == 32'd0 ||
                            (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            issue(f, a, b, ref_mdu(f, a, b), spec ? 2 : 35, 1'b1);
            drain("random_to");
        end

        // Abort a divide mid-iteration; nothing may complete.
        issue(3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        check("busy_before_kill_taken", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_alu_own", {31'd0, alu_own}, 32'd0);
        repeat (40) @(posedge clk);
        issue(3'b000, 32'd3, 32'd3, 32'd9, 35, 1'b1);
        drain("mul_after_kill_to");

        // kill beats start in IDLE.
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("kill_start_still_idle", {31'd0, busy}, 32'd0);

        // start held high while busy, with operands changing underneath.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6; cur_op = 3'b000; own_cnt = 0;
        push_exp(32'd42, 35);
        @(posedge clk); #1;
        funct3 = 3'b101; rs1 = 32'h1234_5678;
        repeat (30) @(posedge clk);
        #1 start = 1'b0;
        drain("held_start_to");
        check("held_start_alu_own_cycles", 32'(own_cnt), 32'd32);

        // start during DONE ignored; start in the following IDLE cycle accepted.
        issue(3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_seen_b2b", {31'd0, done}, 32'd1);
        #1;
        start = 1'b1; funct3 = 3'b111; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1;
        funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6; cur_op = 3'b000;
        push_exp(32'd42, 35);
        @(posedge clk); #1;
        start = 1'b0;
        drain("b2b_to");

        // Reset mid-iteration clears every output.
        issue(3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("alu_own_before_rst_taken", {31'd0, alu_own}, 32'd1);
        @(negedge clk);
        check_reset_outs("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        issue(3'b111, 32'd100, 32'd7, 32'd2, 35, 1'b1);
        drain("after_rst_to");

        check("alu_bus_hygiene", 32'(alu_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
